// File: rtl/onehot_write_decoder_pkg.sv
// Shared types and default sizing for the register-file write-enable decoder.
package onehot_write_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_t;

  localparam int unsigned DEF_SEL_W      = 5;
  localparam int unsigned DEF_ZERO_IDX   = 31;
  localparam int          DEF_GATE_DELAY = 50;

endpackage

// File: rtl/onehot_write_decoder_if.sv
// Write-port bundle between writeback and the register-file enable decoder.
interface onehot_write_decoder_if
  import onehot_write_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = DEF_SEL_W
);
  localparam int unsigned N_OUT = 1 << SEL_W;

  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic             clr_req;
  logic [N_OUT-1:0] dec_out;
  logic             clr_busy;
  logic             clr_done;
  logic             wr_drop;

  modport master (
    output wr_en, wr_sel, clr_req,
    input  dec_out, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  wr_en, wr_sel, clr_req,
    output dec_out, clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/onehot_write_decoder_core.sv
// Combinational enable + select to one-hot decoder, one AND term per output.
module onehot_dec_core
  import onehot_write_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int          GATE_DELAY = DEF_GATE_DELAY
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1 << SEL_W)-1:0] onehot
);
  // Gate delay is a simulation annotation only; the decode itself is zero-delay.
  if (GATE_DELAY < 0) begin : g_bad_delay
    $error("onehot_dec_core: GATE_DELAY must be non-negative");
  end

  for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_term
    assign onehot[i] = en & (sel == SEL_W'(i));
  end
endmodule

// File: rtl/onehot_write_decoder.sv
// Registered one-hot write-enable decoder with zero-register suppression and clear walker.
module onehot_write_decoder
  import onehot_write_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter bit          ZERO_EN    = 1'b1,
  parameter int unsigned ZERO_IDX   = DEF_ZERO_IDX,
  parameter int          GATE_DELAY = DEF_GATE_DELAY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onehot_write_decoder_if.slave  bus
);
  localparam int unsigned      N_OUT = 1 << SEL_W;
  localparam logic [SEL_W-1:0] ZSEL  = SEL_W'(ZERO_IDX);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_OUT - 1);

  if (ZERO_IDX >= N_OUT) begin : g_bad_zero_idx
    $error("onehot_write_decoder: ZERO_IDX must be below 2**SEL_W");
  end

  clr_state_t       state, state_n;
  logic [SEL_W-1:0] cnt, cnt_n;
  logic             dec_en;
  logic [SEL_W-1:0] dec_sel;
  logic [N_OUT-1:0] dec_next;
  logic             drop_n, busy_n, done_n;

  // One decoder serves both the write path and the clear walker via the select mux.
  onehot_dec_core #(
    .SEL_W      (SEL_W),
    .GATE_DELAY (GATE_DELAY)
  ) u_core (
    .en     (dec_en),
    .sel    (dec_sel),
    .onehot (dec_next)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dec_en  = 1'b0;
    dec_sel = bus.wr_sel;
    drop_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_n = CLEAR;
          cnt_n   = '0;
          drop_n  = bus.wr_en;
        end else begin
          dec_en = bus.wr_en && !(ZERO_EN && (bus.wr_sel == ZSEL));
        end
      end
      CLEAR: begin
        busy_n  = 1'b1;
        dec_sel = cnt;
        dec_en  = !(ZERO_EN && (cnt == ZSEL));
        drop_n  = bus.wr_en;
        if (cnt == LAST) state_n = DONE;
        else             cnt_n   = cnt + 1'b1;
      end
      DONE: begin
        done_n  = 1'b1;
        drop_n  = bus.wr_en;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.dec_out  <= '0;
      bus.clr_busy <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.wr_drop  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bus.dec_out  <= dec_next;
      bus.clr_busy <= busy_n;
      bus.clr_done <= done_n;
      bus.wr_drop  <= drop_n;
    end
  end
endmodule

// File: tb/tb_onehot_write_decoder.sv
// Self-checking bench: three decoder configurations driven in lockstep against a position-based model.
module tb_onehot_write_decoder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  onehot_write_decoder_if #(.SEL_W(5)) ifa ();
  onehot_write_decoder_if #(.SEL_W(5)) ifb ();
  onehot_write_decoder_if #(.SEL_W(3)) ifc ();

  onehot_write_decoder #(.SEL_W(5), .ZERO_EN(1'b1), .ZERO_IDX(31), .GATE_DELAY(50))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  onehot_write_decoder #(.SEL_W(5), .ZERO_EN(1'b0), .ZERO_IDX(31), .GATE_DELAY(50))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  onehot_write_decoder #(.SEL_W(3), .ZERO_EN(1'b0), .ZERO_IDX(7), .GATE_DELAY(50))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Model state: pos < 0 idle, 0..n-1 clear position about to be emitted, n = done cycle.
  int          pos[3];
  int          nout[3] = '{32, 32, 8};
  bit          zen[3]  = '{1'b1, 1'b0, 1'b0};
  int          zidx[3] = '{31, 31, 7};
  logic [31:0] e_dec[3];
  logic        e_busy[3], e_done[3], e_drop[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input logic we, input int sel, input logic cr);
    int s = sel % nout[k];
    e_dec[k]  = '0;
    e_busy[k] = 1'b0;
    e_done[k] = 1'b0;
    e_drop[k] = 1'b0;
    if (pos[k] < 0) begin
      if (cr) begin
        e_drop[k] = we;
        pos[k]    = 0;
      end else if (we && !(zen[k] && s == zidx[k])) begin
        e_dec[k] = 32'd1 << s;
      end
    end else if (pos[k] < nout[k]) begin
      e_busy[k] = 1'b1;
      e_drop[k] = we;
      if (!(zen[k] && pos[k] == zidx[k])) e_dec[k] = 32'd1 << pos[k];
      pos[k]++;
    end else begin
      e_done[k] = 1'b1;
      e_drop[k] = we;
      pos[k]    = -1;
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 3; k++) begin
      pos[k]    = -1;
      e_dec[k]  = '0;
      e_busy[k] = 1'b0;
      e_done[k] = 1'b0;
      e_drop[k] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [31:0] od[3];
    logic        ob[3], odn[3], odr[3];
    od[0] = ifa.dec_out;            ob[0] = ifa.clr_busy; odn[0] = ifa.clr_done; odr[0] = ifa.wr_drop;
    od[1] = ifb.dec_out;            ob[1] = ifb.clr_busy; odn[1] = ifb.clr_done; odr[1] = ifb.wr_drop;
    od[2] = {24'b0, ifc.dec_out};   ob[2] = ifc.clr_busy; odn[2] = ifc.clr_done; odr[2] = ifc.wr_drop;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d.dec_out", k), od[k], e_dec[k]);
      chk($sformatf("dut%0d.clr_busy", k), 32'(ob[k]), 32'(e_busy[k]));
      chk($sformatf("dut%0d.clr_done", k), 32'(odn[k]), 32'(e_done[k]));
      chk($sformatf("dut%0d.wr_drop", k), 32'(odr[k]), 32'(e_drop[k]));
      chk($sformatf("dut%0d.onehot", k), 32'($countones(od[k]) <= 1), 32'd1);
      chk($sformatf("dut%0d.busy_and_done", k), 32'(ob[k] && odn[k]), 32'd0);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] sel, input logic cr);
    ifa.wr_en = we; ifa.wr_sel = sel;      ifa.clr_req = cr;
    ifb.wr_en = we; ifb.wr_sel = sel;      ifb.clr_req = cr;
    ifc.wr_en = we; ifc.wr_sel = sel[2:0]; ifc.clr_req = cr;
  endtask

  // Entered and left at a falling edge: drive, step the models, check after the rising edge.
  task automatic cycle(input logic we, input logic [4:0] sel, input logic cr);
    drive(we, sel, cr);
    for (int k = 0; k < 3; k++) model(k, we, int'(sel), cr);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    reset_models();
    drive(1'b1, 5'd3, 1'b0);
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(1'b1, 5'd3, 1'b0);

    for (int i = 0; i < 32; i++) cycle(1'b1, 5'(i), 1'b0);
    cycle(1'b0, 5'd0, 1'b0);

    cycle(1'b0, 5'd0, 1'b1);
    repeat (34) cycle(1'b0, 5'd0, 1'b0);

    cycle(1'b1, 5'd7, 1'b1);
    for (int i = 0; i < 33; i++) cycle(i == 10, 5'd2, (i == 5) || (i == 20));
    repeat (10) cycle(1'b0, 5'd0, 1'b0);

    cycle(1'b0, 5'd0, 1'b1);
    repeat (17) cycle(1'b0, 5'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_models();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 5'd0, 1'b0);
    cycle(1'b0, 5'd0, 1'b1);
    repeat (4) cycle(1'b0, 5'd0, 1'b0);
    repeat (40) cycle(1'b0, 5'd0, 1'b0);

    repeat (400) cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(0, 15) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
